// File: rtl/prom_arbiter.sv
// Two-requester round-robin arbiter for a 32x8 asynchronous PROM.
// Each access holds chip-enable low for ACCESS_CYCLES clocks, then captures the byte and pulses the requester's ack.
module prom_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic [4:0] addr0,
  output logic       ack0,
  input  logic       req1,
  input  logic [4:0] addr1,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [4:0] prom_a,
  output logic       prom_ce_n,
  input  logic [7:0] prom_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       gnt;       // requester owning the current access
  logic       last_gnt;  // requester granted most recently
  logic       pick1;

  // On a tie, hand the PROM to whoever did not get it last time.
  assign pick1 = req1 & (~req0 | ~last_gnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      prom_a    <= '0;
      prom_ce_n <= 1'b1;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt       <= pick1;
            last_gnt  <= pick1;
            prom_a    <= pick1 ? addr1 : addr0;
            prom_ce_n <= 1'b0;
            busy      <= 1'b1;
            cnt       <= CNT_INIT;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata     <= prom_d;
            prom_ce_n <= 1'b1;
            ack0      <= ~gnt;
            ack1      <= gnt;
            state     <= DONE;
          end
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prom_arbiter.sv
// Directed bench for prom_arbiter: three instances (ACCESS_CYCLES 2, 1, 15) each driving its own PROM model.
module tb_prom_arbiter;

  logic       clk;
  logic       reset_n;
  logic [2:0] req0_v, req1_v, ack0_v, ack1_v, busy_v, ce_n_v;
  logic [4:0] addr0_v [3];
  logic [4:0] addr1_v [3];
  logic [4:0] a_v     [3];
  logic [7:0] rdata_v [3];
  logic [7:0] d_v     [3];

  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] word(input logic [4:0] a);
    case (a)
      5'd5:    return 8'hA5;
      5'd0:    return 8'h5A;
      5'd31:   return 8'hC3;
      default: return {a[3:0], a[3:0]};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    prom_arbiter #(.ACCESS_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req0     (req0_v[g]),
      .addr0    (addr0_v[g]),
      .ack0     (ack0_v[g]),
      .req1     (req1_v[g]),
      .addr1    (addr1_v[g]),
      .ack1     (ack1_v[g]),
      .rdata    (rdata_v[g]),
      .busy     (busy_v[g]),
      .prom_a   (a_v[g]),
      .prom_ce_n(ce_n_v[g]),
      .prom_d   (d_v[g])
    );
    assign d_v[g] = ce_n_v[g] ? 8'hFF : word(a_v[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors: chip-enable run length, address stability, ack counts, grant order of instance 0.
  int         run      [3] = '{0, 0, 0};
  int         last_run [3] = '{0, 0, 0};
  logic [4:0] start_a  [3];
  bit         a_moved  [3] = '{0, 0, 0};
  int         ack0_cnt [3] = '{0, 0, 0};
  int         ack1_cnt [3] = '{0, 0, 0};
  int         both_cnt = 0;
  int         order_q[$];
  int         data_q[$];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ce_n_v[i] == 1'b0) begin
        if (run[i] == 0) start_a[i] <= a_v[i];
        else if (a_v[i] != start_a[i]) a_moved[i] <= 1'b1;
        run[i] <= run[i] + 1;
      end else if (run[i] > 0) begin
        last_run[i] <= run[i];
        run[i]      <= 0;
      end
      if (ack0_v[i]) ack0_cnt[i] <= ack0_cnt[i] + 1;
      if (ack1_v[i]) ack1_cnt[i] <= ack1_cnt[i] + 1;
    end
    if ((ack0_v & ack1_v) != 3'b000) both_cnt <= both_cnt + 1;
    if (ack0_v[0]) begin order_q.push_back(0); data_q.push_back(int'(rdata_v[0])); end
    if (ack1_v[0]) begin order_q.push_back(1); data_q.push_back(int'(rdata_v[0])); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    order_q.delete();
    data_q.delete();
  endtask

  task automatic wait_ack(input int i, input bit which);
    int n = 0;
    while (!(which ? ack1_v[i] : ack0_v[i]) && n < 40) begin
      step();
      n++;
    end
    chk("ack_wait", 32'(which ? ack1_v[i] : ack0_v[i]), 32'd1);
  endtask

  int  a0_snap, a1_snap, n;
  bit  seen_b, seen_c;
  logic [7:0] got_b, got_c;
  logic [4:0] baddr [2] = '{5'd0, 5'd31};
  logic [7:0] bexp  [2] = '{8'h5A, 8'hC3};

  initial begin
    reset_n = 1'b0;
    req0_v = '0; req1_v = '0;
    for (int i = 0; i < 3; i++) begin addr0_v[i] = '0; addr1_v[i] = '0; end
    step();
    step();
    chk("rst_ce_n",  32'(ce_n_v[0]), 32'd1);
    chk("rst_busy",  32'(busy_v[0]), 32'd0);
    chk("rst_acks",  32'({ack0_v[0], ack1_v[0]}), 32'd0);
    chk("rst_rdata", 32'(rdata_v[0]), 32'd0);
    chk("rst_prom_a", 32'(a_v[0]), 32'd0);
    reset_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy_v[0]), 32'd0);

    // Single read of word 5
    req0_v[0] = 1'b1; addr0_v[0] = 5'd5;
    step();
    chk("rd_busy",   32'(busy_v[0]), 32'd1);
    chk("rd_ce_lo",  32'(ce_n_v[0]), 32'd0);
    chk("rd_prom_a", 32'(a_v[0]), 32'd5);
    chk("rd_noack",  32'(ack0_v[0]), 32'd0);
    step();
    chk("rd_ce_lo2", 32'(ce_n_v[0]), 32'd0);
    chk("rd_noack2", 32'(ack0_v[0]), 32'd0);
    step();
    chk("rd_ack",    32'(ack0_v[0]), 32'd1);
    chk("rd_data",   32'(rdata_v[0]), 32'hA5);
    chk("rd_ce_hi",  32'(ce_n_v[0]), 32'd1);
    chk("rd_busy_ack", 32'(busy_v[0]), 32'd1);
    req0_v[0] = 1'b0;
    step();
    chk("rd_ack_off",  32'(ack0_v[0]), 32'd0);
    chk("rd_busy_off", 32'(busy_v[0]), 32'd0);
    chk("rd_hold",     32'(rdata_v[0]), 32'hA5);
    step();
    chk("rd_ce_run", 32'(last_run[0]), 32'd2);
    chk("rd_a_stable", 32'(a_moved[0]), 32'd0);

    // Round robin with both requesters held from reset
    do_reset();
    req0_v[0] = 1'b1; addr0_v[0] = 5'd1;
    req1_v[0] = 1'b1; addr1_v[0] = 5'd2;
    n = 0;
    while (data_q.size() < 4 && n < 100) begin step(); n++; end
    req0_v[0] = 1'b0; req1_v[0] = 1'b0;
    chk("rr_count", 32'(data_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", 32'((k < order_q.size()) ? order_q[k] : 9), 32'(k % 2));
      chk("rr_data",  32'((k < data_q.size()) ? data_q[k] : 0), (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    repeat (4) step();
    chk("rr_no_extra", 32'(order_q.size()), 32'd4);

    // Address change after grant is ignored
    req0_v[0] = 1'b1; addr0_v[0] = 5'd3;
    step();
    addr0_v[0] = 5'd7;
    chk("addr_lat", 32'(a_v[0]), 32'd3);
    wait_ack(0, 1'b0);
    chk("addr_data", 32'(rdata_v[0]), 32'h33);
    chk("addr_hold", 32'(a_v[0]), 32'd3);
    req0_v[0] = 1'b0;
    step();
    step();

    // Reset in the second access cycle
    req0_v[0] = 1'b1; addr0_v[0] = 5'd9;
    step();
    step();
    a0_snap = ack0_cnt[0];
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ce_n", 32'(ce_n_v[0]), 32'd1);
    chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
    chk("mid_rst_ack",  32'(ack0_v[0]), 32'd0);
    req0_v[0] = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("mid_rst_rdata", 32'(rdata_v[0]), 32'd0);
    step();
    step();
    chk("mid_rst_no_ack", 32'(ack0_cnt[0]), 32'(a0_snap));
    req1_v[0] = 1'b1; addr1_v[0] = 5'd2;
    wait_ack(0, 1'b1);
    chk("post_rst_data", 32'(rdata_v[0]), 32'h22);
    req1_v[0] = 1'b0;
    step();
    step();

    // req1 dropped mid-access still gets its ack, then nothing further
    a1_snap = ack1_cnt[0];
    req1_v[0] = 1'b1; addr1_v[0] = 5'd4;
    step();
    req1_v[0] = 1'b0;
    wait_ack(0, 1'b1);
    chk("drop_data", 32'(rdata_v[0]), 32'h44);
    repeat (3) step();
    chk("drop_busy", 32'(busy_v[0]), 32'd0);
    chk("drop_ce_n", 32'(ce_n_v[0]), 32'd1);
    chk("drop_ack_once", 32'(ack1_cnt[0]), 32'(a1_snap + 1));

    // Boundary parameters and addresses
    for (int t = 0; t < 2; t++) begin
      req0_v[1] = 1'b1; addr0_v[1] = baddr[t];
      req0_v[2] = 1'b1; addr0_v[2] = baddr[t];
      seen_b = 1'b0; seen_c = 1'b0; got_b = '0; got_c = '0;
      n = 0;
      while (!(seen_b && seen_c) && n < 60) begin
        step();
        n++;
        if (ack0_v[1] && !seen_b) begin got_b = rdata_v[1]; req0_v[1] = 1'b0; seen_b = 1'b1; end
        if (ack0_v[2] && !seen_c) begin got_c = rdata_v[2]; req0_v[2] = 1'b0; seen_c = 1'b1; end
      end
      req0_v[1] = 1'b0; req0_v[2] = 1'b0;
      chk("bnd_seen", 32'({seen_b, seen_c}), 32'd3);
      step();
      step();
      chk("bnd1_data", 32'(got_b), 32'(bexp[t]));
      chk("bnd15_data", 32'(got_c), 32'(bexp[t]));
      chk("bnd1_ce_run", 32'(last_run[1]), 32'd1);
      chk("bnd15_ce_run", 32'(last_run[2]), 32'd15);
    end
    chk("bnd_a_stable", 32'({a_moved[1], a_moved[2]}), 32'd0);
    chk("ack_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prom_arbiter.md
PROM_ARBITER -- requirements
Module: prom_arbiter

Interface
REQ-001 Parameter: ACCESS_CYCLES, default 2, number of clocks the PROM chip-enable is held low before data is sampled; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 read request, level, held until ack0.
REQ-005 addr0  input  5  requester 0 PROM word address.
REQ-006 ack0  output  1  one-cycle pulse: requester 0 read complete, rdata valid.
REQ-007 req1  input  1  requester 1 read request, level, held until ack1.
REQ-008 addr1  input  5  requester 1 PROM word address.
REQ-009 ack1  output  1  one-cycle pulse: requester 1 read complete, rdata valid.
REQ-010 rdata  output  8  captured PROM byte, shared by both requesters.
REQ-011 busy  output  1  high while an access is in progress, from the grant edge until the ack cycle ends.
REQ-012 prom_a  output  5  address to 32x8 PROM {A4..A0}.
REQ-013 prom_ce_n  output  1  PROM chip enable, active low.
REQ-014 prom_d  input  8  PROM data {O7..O0}; high-Z/weak-1 when prom_ce_n high.

Function
REQ-015 FSM states: IDLE, ACCESS, DONE; all outputs registered.
REQ-016 IDLE, no request: stay IDLE; prom_ce_n=1, ack0=ack1=0, busy=0.
REQ-017 IDLE, any req at an edge: grant one requester, latch its address into prom_a, set prom_ce_n=0, busy=1, load counter with ACCESS_CYCLES-1, go to ACCESS.
REQ-018 Arbitration: only one req high -> grant it; both high -> grant the requester not granted last (round-robin); the last-grant pointer updates at every grant.
REQ-019 ACCESS: counter != 0 -> decrement and stay; counter == 0 -> capture prom_d into rdata, set prom_ce_n=1, assert ack of the granted requester, go to DONE.
REQ-020 prom_ce_n is low for exactly ACCESS_CYCLES clocks per access; prom_a is stable for the whole low period.
REQ-021 DONE: deassert ack and busy, go to IDLE; ack is high for exactly one clock.
REQ-022 Latency: req sampled at grant edge E0 -> ack high during the cycle after edge E0+ACCESS_CYCLES; back-to-back accesses are separated by at least one IDLE cycle (minimum period ACCESS_CYCLES+2 clocks).
REQ-023 rdata holds its value from capture until the next capture; it is not cleared on ack deassertion.
REQ-024 addrN changes after the grant edge are ignored for the current access.
REQ-025 reqN dropped mid-access: the access completes and ackN still pulses.
REQ-026 A requester still holding req after its ack is re-sampled in IDLE and round-robin applies.
REQ-027 Only one ack is ever high in any cycle; no ack is issued without a prior grant.

Reset
REQ-028 reset_n low forces, asynchronously: state=IDLE, prom_ce_n=1, prom_a=0, rdata=0, ack0=ack1=0, busy=0, counter=0, last-grant=requester 1 (so requester 0 wins the first tie).
REQ-029 Reset during ACCESS abandons the access; no ack is issued for it, and rdata reads 0 after release.
REQ-030 After reset_n rises, the first grant occurs no earlier than the first rising edge with reset_n high.

Verification
REQ-031 PROM model with word 5 = 8'hA5; req0=1, addr0=5, ACCESS_CYCLES=2 -> prom_ce_n low 2 clocks, prom_a=5, ack0 pulses 1 clock, rdata=8'hA5.
REQ-032 Simultaneous req0 (addr 1 = 8'h11) and req1 (addr 2 = 8'h22) held continuously, first access after reset -> grant order 0,1,0,1; rdata alternates 11,22; acks never overlap.
REQ-033 addr0 changed from 3 to 7 one cycle after grant -> prom_a stays 3 and rdata = word 3.
REQ-034 reset_n asserted in the 2nd ACCESS cycle -> prom_ce_n=1 and busy=0 immediately, with no ack; a req issued after release completes normally.
REQ-035 ACCESS_CYCLES=1 and ACCESS_CYCLES=15 with addresses 0 and 31 -> chip-enable low period equals the parameter, and data at both boundary addresses is correct.
REQ-036 req1 dropped mid-access -> ack1 still pulses once, and the next IDLE with no req grants nothing.
